// File: rtl/nonce_dispatcher.sv
// nonce_dispatcher: hands consecutive nonces to idle SHA cores in round-robin order and reports
// the first winning nonce or exhaustion of the nonce space; grants are combinational, results one cycle after the deciding done.
module nonce_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] core_ready,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_hit,
  output logic [NUM_CORES-1:0] core_start,
  output logic [NONCE_W-1:0]   core_nonce,
  output logic                 busy,
  output logic                 found,
  output logic [NONCE_W-1:0]   found_nonce,
  output logic                 exhausted
);

  localparam int IDX_W = $clog2(NUM_CORES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_FOUND,
    S_EXHAUST
  } state_t;

  state_t               state, state_nxt;
  logic [NONCE_W-1:0]   next_nonce;
  logic                 last_issued;
  logic [NUM_CORES-1:0] inflight;
  logic [NONCE_W-1:0]   held_nonce [NUM_CORES];
  logic [IDX_W-1:0]     rr;

  logic                 searching;
  logic                 any_hit;
  logic                 gnt_vld;
  logic                 grant;
  logic                 last_nonce;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] hit_vec;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     hit_idx;
  logic [IDX_W-1:0]     rr_nxt;

  assign searching  = (state == S_DISPATCH) || (state == S_DRAIN);
  assign hit_vec    = searching ? (core_done & core_hit & inflight) : '0;
  assign any_hit    = |hit_vec;
  // A core whose done arrives this cycle is still marked inflight, so it cannot be re-granted yet.
  assign eligible   = core_ready & ~inflight;
  assign last_nonce = &next_nonce;
  assign grant      = (state == S_DISPATCH) && !abort && !any_hit && !last_issued && gnt_vld;
  assign rr_nxt     = (gnt_idx == IDX_W'(NUM_CORES - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_comb begin : rr_search
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!gnt_vld && eligible[IDX_W'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
  end

  always_comb begin : lowest_hit
    hit_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (start) state_nxt = S_DISPATCH;
        S_DISPATCH: begin
          if (any_hit)                  state_nxt = S_FOUND;
          else if (grant && last_nonce) state_nxt = S_DRAIN;
        end
        S_DRAIN: begin
          if (any_hit)                           state_nxt = S_FOUND;
          else if ((inflight & ~core_done) == '0) state_nxt = S_EXHAUST;
        end
        S_FOUND:    state_nxt = S_IDLE;
        S_EXHAUST:  state_nxt = S_IDLE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    core_start = '0;
    core_nonce = '0;
    if (grant) begin
      core_start[gnt_idx] = 1'b1;
      core_nonce          = next_nonce;
    end
    busy      = searching;
    found     = (state == S_FOUND);
    exhausted = (state == S_EXHAUST);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      next_nonce  <= '0;
      last_issued <= 1'b0;
      inflight    <= '0;
      rr          <= '0;
      found_nonce <= '0;
      for (int i = 0; i < NUM_CORES; i++) held_nonce[i] <= '0;
    end else if (abort) begin
      inflight <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            next_nonce  <= '0;
            last_issued <= 1'b0;
            inflight    <= '0;
            rr          <= '0;
            found_nonce <= '0;
          end
        end
        S_DISPATCH, S_DRAIN: begin
          inflight <= (inflight & ~core_done) | core_start;
          if (any_hit) found_nonce <= held_nonce[hit_idx];
          if (grant) begin
            held_nonce[gnt_idx] <= next_nonce;
            rr                  <= rr_nxt;
            next_nonce          <= next_nonce + NONCE_W'(1);
            if (last_nonce) last_issued <= 1'b1;
          end
        end
        default: inflight <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher: vector table, exhaustion and async-reset sequences, then random
// traffic checked against a cycle-level behavioural model of the dispatch rules.
module tb_nonce_dispatcher;

  localparam int NC = 4;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start, abort;
  logic [NC-1:0] core_ready, core_done, core_hit;
  logic [NC-1:0] core_start;
  logic [NW-1:0] core_nonce;
  logic          busy, found, exhausted;
  logic [NW-1:0] found_nonce;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nonce_dispatcher #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .core_ready(core_ready), .core_done(core_done), .core_hit(core_hit),
    .core_start(core_start), .core_nonce(core_nonce), .busy(busy),
    .found(found), .found_nonce(found_nonce), .exhausted(exhausted)
  );

  typedef struct {
    int st, ab, rdy, dn, ht;
    int cs, nc, bsy, fnd, fn, exh;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int st, input int ab, input int rdy, input int dn, input int ht,
                              input int cs, input int nc, input int bsy, input int fnd, input int fn,
                              input int exh);
    vec_t v;
    v.st = st; v.ab = ab; v.rdy = rdy; v.dn = dn; v.ht = ht;
    v.cs = cs; v.nc = nc; v.bsy = bsy; v.fnd = fnd; v.fn = fn; v.exh = exh;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int st, input int ab, input int rdy, input int dn, input int ht);
    start      = (st != 0);
    abort      = (ab != 0);
    core_ready = NC'(rdy);
    core_done  = NC'(dn);
    core_hit   = NC'(ht);
  endtask

  task automatic apply_row(input vec_t v, input int row);
    drive(v.st, v.ab, v.rdy, v.dn, v.ht);
    @(negedge clk);
    chk($sformatf("row%0d core_start", row), int'(core_start), v.cs);
    if (v.cs != 0) chk($sformatf("row%0d core_nonce", row), int'(core_nonce), v.nc);
    chk($sformatf("row%0d busy", row), int'(busy), v.bsy);
    chk($sformatf("row%0d found", row), int'(found), v.fnd);
    chk($sformatf("row%0d found_nonce", row), int'(found_nonce), v.fn);
    chk($sformatf("row%0d exhausted", row), int'(exhausted), v.exh);
    @(posedge clk);
    #1;
  endtask

  // Cores finish 3 cycles after dispatch, never hit. Optionally reset right after entering DRAIN.
  task automatic run_auto(input bit rst_in_drain);
    int cnt [16];
    int iss [NC];
    bit pend [NC];
    int issued, exh_n, exh_cyc, last_done, bad;
    logic [NC-1:0] dn;
    issued = 0; exh_n = 0; exh_cyc = -1; last_done = -100;
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    for (int i = 0; i < NC; i++) begin iss[i] = 0; pend[i] = 1'b0; end
    drive(1, 0, 15, 0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < NC; i++) dn[i] = pend[i] && (cyc == iss[i] + 3);
      core_done = dn;
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (dn[i]) begin pend[i] = 1'b0; last_done = cyc; end
        if (core_start[i]) begin
          cnt[int'(core_nonce)]++;
          iss[i] = cyc; pend[i] = 1'b1; issued++;
        end
      end
      if (exhausted) begin
        exh_n++; exh_cyc = cyc;
        chk("exh busy_low", int'(busy), 0);
      end
      if (rst_in_drain && issued == 16) begin
        @(posedge clk); #1;
        chk("drain busy_before_reset", int'(busy), 1);
        core_done = '0;
        #1 n_rst = 1'b0;
        #1;
        chk("areset busy", int'(busy), 0);
        chk("areset core_start", int'(core_start), 0);
        chk("areset found", int'(found), 0);
        chk("areset exhausted", int'(exhausted), 0);
        chk("areset found_nonce", int'(found_nonce), 0);
        #3 n_rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("post_reset core_start", int'(core_start), 1);
        chk("post_reset core_nonce", int'(core_nonce), 0);
        @(posedge clk); #1;
        return;
      end
      if (exh_n > 0 && cyc > exh_cyc + 2) break;
      @(posedge clk); #1;
    end
    if (rst_in_drain) begin
      chk("drain reached", issued, 16);
      return;
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (cnt[i] != 1) bad++;
    chk("exh issued_total", issued, 16);
    chk("exh nonce_once_each_bad", bad, 0);
    chk("exh pulse_count", exh_n, 1);
    chk("exh latency_cycle", exh_cyc, last_done + 1);
  endtask

  // Behavioural model: mode 0 idle, 1 dispatch, 2 drain, 3 found, 4 exhausted.
  int m_mode, m_nxt, m_rr, m_fn;
  bit [NC-1:0] m_inf;
  int m_held [NC];

  task automatic run_random(input int ncyc);
    int st, ab, rdy, dn, ht, hits, g, idx, lo;
    int ecs, enc, eb, ef, ee;
    bit ok;
    for (int c = 0; c < ncyc; c++) begin
      st  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      ab  = ($urandom_range(0, 59) == 0) ? 1 : 0;
      rdy = int'($urandom_range(0, 15));
      dn  = int'($urandom_range(0, 15) & $urandom_range(0, 15));
      ht  = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 15)) : 0;
      hits = (m_mode == 1 || m_mode == 2) ? (dn & ht & int'(m_inf)) : 0;
      g = -1;
      if (m_mode == 1 && ab == 0 && hits == 0)
        for (int k = 0; k < NC; k++) begin
          idx = (m_rr + k) % NC;
          if (g < 0 && rdy[idx] && !m_inf[idx]) g = idx;
        end
      ecs = (g >= 0) ? (1 << g) : 0;
      enc = m_nxt;
      eb  = (m_mode == 1 || m_mode == 2) ? 1 : 0;
      ef  = (m_mode == 3) ? 1 : 0;
      ee  = (m_mode == 4) ? 1 : 0;
      drive(st, ab, rdy, dn, ht);
      @(negedge clk);
      ok = (int'(core_start) == ecs) && (ecs == 0 || int'(core_nonce) == enc) &&
           (int'(busy) == eb) && (int'(found) == ef) && (int'(exhausted) == ee) &&
           (int'(found_nonce) == m_fn);
      checks++;
      if (!ok) begin
        errs++;
        $display("FAIL rand c%0d: got cs=%0h nc=%0d busy=%0d found=%0d fn=%0d exh=%0d expected cs=%0h nc=%0d busy=%0d found=%0d fn=%0d exh=%0d",
                 c, core_start, core_nonce, busy, found, found_nonce, exhausted, ecs, enc, eb, ef, m_fn, ee);
      end
      @(posedge clk); #1;
      if (ab != 0) begin
        m_mode = 0; m_inf = '0;
      end else if (m_mode == 0) begin
        if (st != 0) begin m_mode = 1; m_nxt = 0; m_rr = 0; m_inf = '0; m_fn = 0; end
      end else if (m_mode == 1 || m_mode == 2) begin
        m_inf = m_inf & ~NC'(dn);
        if (hits != 0) begin
          lo = -1;
          for (int i = NC - 1; i >= 0; i--) if (hits[i]) lo = i;
          m_fn = m_held[lo];
          m_mode = 3;
        end else if (g >= 0) begin
          m_held[g] = m_nxt;
          m_inf[g] = 1'b1;
          m_rr = (g + 1) % NC;
          if (m_nxt == 15) m_mode = 2;
          m_nxt = (m_nxt + 1) % 16;
        end else if (m_mode == 2 && m_inf == '0) begin
          m_mode = 4;
        end
      end else begin
        m_mode = 0; m_inf = '0;
      end
    end
  endtask

  initial begin
    // start, ab, rdy, dn, ht | cs, nc, busy, found, fn, exh
    tbl.push_back(mk(0, 0, 15, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 15, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  4, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  8, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 1, 0,  0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  1, 4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 2, 0,  0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  2, 5, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 4, 0,  0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  4, 6, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 4, 4,  0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  0, 0, 0, 1, 6, 0));
    tbl.push_back(mk(0, 0, 15, 1, 0,  0, 0, 0, 0, 6, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  0, 0, 0, 0, 6, 0));
    tbl.push_back(mk(1, 0, 15, 0, 0,  0, 0, 0, 0, 6, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  4, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  8, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 15, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  1, 4, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  2, 5, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  4, 6, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  8, 7, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 7, 0,  0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  1, 8, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  2, 9, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  4, 10, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 10, 10, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  0, 0, 0, 1, 9, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  0, 0, 0, 0, 9, 0));
    tbl.push_back(mk(1, 0, 15, 0, 0,  0, 0, 0, 0, 9, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 15, 1, 1,  0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 15, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 15, 0, 0,  0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 0, 0,  0, 0, 0, 0, 0, 0));

    n_rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    #3;
    chk("reset core_start", int'(core_start), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset found", int'(found), 0);
    chk("reset found_nonce", int'(found_nonce), 0);
    chk("reset exhausted", int'(exhausted), 0);
    #9 n_rst = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < tbl.size(); r++) apply_row(tbl[r], r);

    run_auto(1'b0);
    run_auto(1'b1);

    drive(0, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    m_mode = 0; m_nxt = 0; m_rr = 0; m_fn = 0; m_inf = '0;
    for (int i = 0; i < NC; i++) m_held[i] = 0;
    run_random(3000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
